// File: rtl/casez_sel_gen.sv
// Purpose: turns a 4-bit result code back into the select pattern that a casez decoder maps to that code.
// Latency: the pattern is registered and appears the cycle after accept; it is held for HOLD_CYCLES, then a 1-cycle done follows.
// Backpressure: in_ready is high only in IDLE; one code is taken per IDLE visit, and abort in DRIVE drops the pattern early.
module casez_sel_gen #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       code_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic [3:0]       sel_out,
    output logic             sel_valid,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Hold counter reload value: the counter runs HOLD_CYCLES-1 down to 0.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sel_out_q, sel_out_d;
    logic             sel_valid_q, sel_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Select pattern that the matching casez decoder resolves to each legal code.
    function automatic logic [3:0] code_to_sel(input logic [3:0] code);
        logic [3:0] sel;
        case (code)
            4'd0:    sel = 4'b0000;
            4'd1:    sel = 4'b1000;
            4'd2:    sel = 4'b0100;
            4'd3:    sel = 4'b0010;
            4'd4:    sel = 4'b0001;
            4'd5:    sel = 4'b1100;
            4'd6:    sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Codes 7..15 have no select pattern and are reported as errors.
    logic code_legal;
    assign code_legal = (code_in < 4'd7);

    // A code is only accepted while idle.
    assign in_ready = (state_q == IDLE);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_out_d   = sel_out_q;
        sel_valid_d = sel_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (code_legal) begin
                        sel_out_d   = code_to_sel(code_in);
                        sel_valid_d = 1'b1;
                        cnt_d       = HOLD_LOAD;
                        state_d     = DRIVE;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                end
            end
            DRIVE: begin
                // Abort wins over a hold that happens to be finishing this cycle.
                if (abort) begin
                    sel_out_d   = 4'b0000;
                    sel_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q == '0) begin
                    sel_out_d   = 4'b0000;
                    sel_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                sel_out_d   = 4'b0000;
                sel_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any live pattern immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_out_q   <= 4'b0000;
            sel_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_out_q   <= sel_out_d;
            sel_valid_q <= sel_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign sel_out   = sel_out_q;
    assign sel_valid = sel_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_casez_sel_gen.sv
// Purpose: checks casez_sel_gen against a transaction-level model (pattern table, hold timeline, saturating error count).
// Latency: expects the pattern 1 cycle after accept, held HOLD cycles, then done, then idle.
// Backpressure: exercises held in_valid, abort in every state, and reset mid-hold.
module tb_casez_sel_gen;

    localparam int HOLD  = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       code_in = 4'd0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             abort = 1'b0;
    logic [3:0]       sel_out;
    logic             sel_valid;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    int tests = 0;
    int fails = 0;
    int err_model = 0;

    // Expected select pattern for each legal code.
    logic [3:0] pat [0:6] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b1111};

    casez_sel_gen #(.HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .sel_out   (sel_out),
        .sel_valid (sel_valid),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one code from an IDLE cycle and follows the whole expected timeline.
    // abort_at = k (1..HOLD) raises abort during the k-th DRIVE cycle; 0 = no abort.
    task automatic run_code(input logic [3:0] code, input int abort_at, input bit keep_valid,
                            input bit abort_idle, input bit abort_done);
        logic [3:0] exp_pat;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        code_in  = code;
        in_valid = 1'b1;
        abort    = abort_idle;
        tick();
        abort    = 1'b0;
        in_valid = keep_valid;
        code_in  = 4'($urandom);
        if (code >= 4'd7) begin
            err_model = (err_model == 255) ? 255 : err_model + 1;
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_cnt", 32'(err_cnt), 32'(err_model));
            chk("illegal_sel_valid", 32'(sel_valid), 32'd0);
            chk("illegal_sel_out", 32'(sel_out), 32'd0);
            chk("illegal_in_ready", 32'(in_ready), 32'd1);
            if (!keep_valid) begin
                tick();
                chk("err_drop", 32'(err), 32'd0);
            end
            return;
        end
        exp_pat = pat[code];
        for (int k = 1; k <= HOLD; k++) begin
            chk("sel_out_hold", 32'(sel_out), 32'(exp_pat));
            chk("sel_valid_hold", 32'(sel_valid), 32'd1);
            chk("in_ready_hold", 32'(in_ready), 32'd0);
            chk("done_hold", 32'(done), 32'd0);
            chk("err_hold", 32'(err), 32'd0);
            if (k == abort_at) abort = 1'b1;
            code_in = 4'($urandom);
            tick();
            abort = 1'b0;
            if (k == abort_at) begin
                chk("abort_sel_out", 32'(sel_out), 32'd0);
                chk("abort_sel_valid", 32'(sel_valid), 32'd0);
                chk("abort_in_ready", 32'(in_ready), 32'd1);
                chk("abort_no_done", 32'(done), 32'd0);
                return;
            end
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_sel_out", 32'(sel_out), 32'd0);
        chk("done_sel_valid", 32'(sel_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        abort = abort_done;
        tick();
        abort = 1'b0;
        chk("done_drop", 32'(done), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state, observed while reset is held.
        #2;
        chk("rst_sel_out", 32'(sel_out), 32'd0);
        chk("rst_sel_valid", 32'(sel_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single code 1 with the default hold.
        run_code(4'd1, 0, 1'b0, 1'b0, 1'b0);

        // All legal codes back-to-back with in_valid held high.
        for (int c = 0; c <= 6; c++) run_code(4'(c), 0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();

        // Illegal code followed immediately by a legal one.
        run_code(4'd9, 0, 1'b1, 1'b0, 1'b0);
        run_code(4'd2, 0, 1'b0, 1'b0, 1'b0);

        // Abort in the second DRIVE cycle, and abort on the last one (beats done).
        run_code(4'd5, 2, 1'b0, 1'b0, 1'b0);
        run_code(4'd6, HOLD, 1'b0, 1'b0, 1'b0);

        // Abort in IDLE and DONE is ignored.
        run_code(4'd4, 0, 1'b0, 1'b1, 1'b1);

        // Reset mid-DRIVE clears outputs at once, including the error count.
        code_in  = 4'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_sel_out", 32'(sel_out), 32'(pat[3]));
        tick();
        #2 rst = 1'b1;
        #1;
        err_model = 0;
        chk("midrst_sel_out", 32'(sel_out), 32'd0);
        chk("midrst_sel_valid", 32'(sel_valid), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < HOLD + 2; i++) begin
            tick();
            chk("post_rst_no_done", 32'(done), 32'd0);
        end

        // Saturation of the error count.
        for (int i = 0; i < 300; i++) run_code(4'(7 + (i % 9)), 0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
        chk("err_drop_after_sat", 32'(err), 32'd0);

        // Clear the count again, then randomized transactions.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        err_model = 0;
        tick();
        for (int i = 0; i < 60; i++) begin
            logic [3:0] c;
            int ab;
            c  = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, HOLD)) : 0;
            run_code(c, ab, 1'($urandom), 1'($urandom), 1'($urandom));
            if (in_valid && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        tick();
        chk("final_err_cnt", 32'(err_cnt), 32'(err_model));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
